syscall_console: RTL and testbench

Consumes syscall requests leaving the CPU's execute stage and turns them into a byte stream on a console port with a valid/ready handshake. Requests are buffered in a small FIFO so the pipeline stalls only when the buffer is full. A sequential binary-to-decimal converter renders `print_int`; `exit` raises a sticky `halted` flag. The block sits downstream of the CPU top level, fed by the EX-stage syscall wires, and its `syscall_full` output goes back to the hazard unit as a stall source.

---
 rtl/syscall_console.sv | 216 +++++++++++++++++++++
 tb/tb_syscall_console.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_console.sv
// Syscall request FIFO feeding a console byte stream; print_int is rendered by
// repeated subtraction of powers of ten, exit latches a terminal halted state.
module syscall_console #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_syscall_e,
  input  logic [31:0] syscall_funct_e,
  input  logic [31:0] syscall_param_1_e,
  output logic        syscall_full,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        pending,
  output logic        halted
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIGN  = 3'd1,
    DIGIT = 3'd2,
    EMIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      4'd9:    pow10 = 32'h3B9A_CA00;
      default: pow10 = 32'd1;
    endcase
  endfunction

  state_t      state_r, state_n;
  logic [31:0] funct_mem_r [FIFO_DEPTH];
  logic [31:0] param_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] count_r, count_n;
  logic [31:0] mag_r, mag_n, pow_s, head_funct_s, head_param_s;
  logic [3:0]  idx_r, idx_n, digit_r, digit_n;
  logic        started_r, started_n, is_int_r, is_int_n;
  logic [7:0]  char_data_r, char_data_n;
  logic        char_valid_r, char_valid_n, full_r, full_n;
  logic        pending_r, pending_n, halted_r, halted_n;
  logic        push_s, pop_s;

  assign push_s       = is_syscall_e && !full_r && !halted_r;
  assign head_funct_s = funct_mem_r[rd_ptr_r];
  assign head_param_s = param_mem_r[rd_ptr_r];
  assign pow_s        = pow10(idx_r);

  // Request storage; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      funct_mem_r[wr_ptr_r] <= syscall_funct_e;
      param_mem_r[wr_ptr_r] <= syscall_param_1_e;
    end
  end

  // State, conversion datapath, FIFO bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      mag_r        <= 32'd0;
      idx_r        <= 4'd0;
      digit_r      <= 4'd0;
      started_r    <= 1'b0;
      is_int_r     <= 1'b0;
      char_data_r  <= 8'd0;
      char_valid_r <= 1'b0;
      full_r       <= 1'b0;
      pending_r    <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_n;
      wr_ptr_r     <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r     <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r      <= count_n;
      mag_r        <= mag_n;
      idx_r        <= idx_n;
      digit_r      <= digit_n;
      started_r    <= started_n;
      is_int_r     <= is_int_n;
      char_data_r  <= char_data_n;
      char_valid_r <= char_valid_n;
      full_r       <= full_n;
      pending_r    <= pending_n;
      halted_r     <= halted_n;
    end
  end

  // Next-state and conversion datapath.
  always_comb begin
    state_n     = state_r;
    mag_n       = mag_r;
    idx_n       = idx_r;
    digit_n     = digit_r;
    started_n   = started_r;
    is_int_n    = is_int_r;
    char_data_n = char_data_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {(AW+1){1'b0}}) begin
          pop_s = 1'b1;
          if (head_funct_s == 32'd11) begin
            is_int_n    = 1'b0;
            char_data_n = head_param_s[7:0];
            state_n     = EMIT;
          end else if (head_funct_s == 32'd10) begin
            state_n = HALT;
          end else if (head_funct_s == 32'd1) begin
            // Two's-complement negate also maps -2^31 onto 0x80000000.
            is_int_n  = 1'b1;
            mag_n     = head_param_s[31] ? (32'd0 - head_param_s) : head_param_s;
            idx_n     = 4'd9;
            digit_n   = 4'd0;
            started_n = 1'b0;
            if (head_param_s[31]) begin
              char_data_n = 8'h2D;
              state_n     = SIGN;
            end else begin
              state_n = DIGIT;
            end
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SIGN: begin
        if (char_ready) begin
          state_n = DIGIT;
        end else begin
          state_n = SIGN;
        end
      end
      DIGIT: begin
        if (mag_r >= pow_s) begin
          mag_n   = mag_r - pow_s;
          digit_n = digit_r + 4'd1;
        end else if (digit_r != 4'd0 || started_r || idx_r == 4'd0) begin
          char_data_n = 8'h30 + {4'd0, digit_r};
          started_n   = 1'b1;
          state_n     = EMIT;
        end else begin
          idx_n = idx_r - 4'd1;
        end
      end
      EMIT: begin
        if (char_ready) begin
          if (is_int_r && idx_r != 4'd0) begin
            idx_n   = idx_r - 4'd1;
            digit_n = 4'd0;
            state_n = DIGIT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = EMIT;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Occupancy; HALT flushes whatever is still buffered.
  always_comb begin
    if (state_r == HALT) begin
      count_n = {(AW+1){1'b0}};
    end else if (push_s && !pop_s) begin
      count_n = count_r + (AW+1)'(1);
    end else if (!push_s && pop_s) begin
      count_n = count_r - (AW+1)'(1);
    end else begin
      count_n = count_r;
    end
  end

  // Output values for the next cycle, decoded from next state and occupancy.
  always_comb begin
    char_valid_n = (state_n == SIGN) || (state_n == EMIT);
    halted_n     = (state_n == HALT);
    full_n       = (count_n == DEPTH_CNT) && (state_n != HALT);
    pending_n    = (state_n != HALT) &&
                   ((count_n != {(AW+1){1'b0}}) || (state_n != IDLE));
  end

  assign char_valid   = char_valid_r;
  assign char_data    = char_data_r;
  assign syscall_full = full_r;
  assign pending      = pending_r;
  assign halted       = halted_r;

endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: vector table, hand-written corner sequences and
// randomized traffic compared against a string-level model of console output.
module tb_syscall_console;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        is_syscall_e = 1'b0;
  logic [31:0] syscall_funct_e = 32'd0;
  logic [31:0] syscall_param_1_e = 32'd0;
  logic        syscall_full, char_valid, char_ready, pending, halted;
  logic [7:0]  char_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  byte got[$];

  typedef struct packed {
    logic [31:0] funct;
    logic [31:0] param;
    logic [7:0]  lat;
    logic [7:0]  first;
  } vec_t;

  vec_t  vt [9];
  string vexp [9];

  syscall_console #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .is_syscall_e(is_syscall_e),
    .syscall_funct_e(syscall_funct_e), .syscall_param_1_e(syscall_param_1_e),
    .syscall_full(syscall_full), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .pending(pending), .halted(halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // A byte seen valid and ready at the falling edge transfers on the next rise.
  always @(negedge clock) begin
    if (reset === 1'b0 && char_valid === 1'b1 && char_ready === 1'b1) got.push_back(char_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string exp);
    string s = "";
    foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
    checks++;
    if (s != exp) begin
      errors++;
      $display("FAIL %s actual=\"%s\" expected=\"%s\"", name, s, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Presents a request until it is taken; n is the cycle at whose end it enqueues.
  task automatic send(input logic [31:0] f, input logic [31:0] p, output int n, output int stalls);
    bit ok = 1'b0;
    stalls = 0;
    n = -1;
    @(posedge clock); #1;
    is_syscall_e = 1'b1;
    syscall_funct_e = f;
    syscall_param_1_e = p;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (syscall_full !== 1'b1) begin
        n = cyc;
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled expected=accepted");
    end
    @(posedge clock); #1;
    is_syscall_e = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (char_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_valid_timeout actual=none expected=char_valid");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (pending === 1'b0 && char_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
  endtask

  initial begin
    int n, st, at;
    string exp;
    bit mhalt;
    bit rnd_done;

    vt[0] = '{32'd11, 32'h0000_0041, 8'd2,  8'h41}; vexp[0] = "A";
    vt[1] = '{32'd1,  32'h8000_0000, 8'd2,  8'h2D}; vexp[1] = "-2147483648";
    vt[2] = '{32'd1,  32'h0000_0000, 8'd12, 8'h30}; vexp[2] = "0";
    vt[3] = '{32'd1,  32'd1000000,   8'd0,  8'h00}; vexp[3] = "1000000";
    vt[4] = '{32'd1,  32'hFFFF_FFFF, 8'd2,  8'h2D}; vexp[4] = "-1";
    vt[5] = '{32'd1,  32'h7FFF_FFFF, 8'd0,  8'h00}; vexp[5] = "2147483647";
    vt[6] = '{32'd5,  32'h0000_0041, 8'd0,  8'h00}; vexp[6] = "";
    vt[7] = '{32'd1,  32'd7,         8'd19, 8'h37}; vexp[7] = "7";
    vt[8] = '{32'd11, 32'h0000_0161, 8'd2,  8'h61}; vexp[8] = "a";

    char_ready = 1'b1;
    do_reset();
    @(negedge clock);
    chk("rst_char_valid", {31'd0, char_valid}, 32'd0);
    chk("rst_char_data", {24'd0, char_data}, 32'd0);
    chk("rst_full", {31'd0, syscall_full}, 32'd0);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Single requests with console always ready.
    for (int v = 0; v < 9; v++) begin
      got.delete();
      send(vt[v].funct, vt[v].param, n, st);
      if (vt[v].lat != 8'd0) begin
        wait_valid(at);
        chk($sformatf("latency_%0d", v), at - n, {24'd0, vt[v].lat});
        chk($sformatf("first_byte_%0d", v), {24'd0, char_data}, {24'd0, vt[v].first});
      end
      wait_idle(500);
      chk_str($sformatf("vector_%0d", v), vexp[v]);
      chk($sformatf("pending_drop_%0d", v), {31'd0, pending}, 32'd0);
    end

    // Backpressure: '4' must be held while the console stalls.
    got.delete();
    char_ready = 1'b0;
    send(32'd1, 32'd42, n, st);
    wait_valid(at);
    chk("bp_first", {24'd0, char_data}, 32'h34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold_valid", {31'd0, char_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, char_data}, 32'h34);
    end
    @(posedge clock); #1;
    char_ready = 1'b1;
    wait_idle(500);
    chk_str("bp_string", "42");

    // FIFO full: five buffered prints fill it, a sixth stalls until the drain.
    got.delete();
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'd11, 32'd97 + i, n, st);
    @(negedge clock);
    chk("full_rises", {31'd0, syscall_full}, 32'd1);
    fork
      send(32'd11, 32'd102, n, st);
      begin
        repeat (5) @(posedge clock);
        #1 char_ready = 1'b1;
      end
    join
    chk("blocked_stalled", {31'd0, st != 0}, 32'd1);
    wait_idle(500);
    chk_str("fifo_order", "abcdef");
    chk("full_clear", {31'd0, syscall_full}, 32'd0);

    // Exit after a print; later requests are dropped.
    got.delete();
    send(32'd11, 32'd120, n, st);
    send(32'd10, 32'd0, n, st);
    send(32'd11, 32'd121, n, st);
    wait_idle(500);
    chk("exit_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 6; i++) send(32'd11, 32'd113, n, st);
    repeat (4) @(negedge clock);
    chk("exit_full_low", {31'd0, syscall_full}, 32'd0);
    chk("exit_no_valid", {31'd0, char_valid}, 32'd0);
    chk("exit_pending_low", {31'd0, pending}, 32'd0);
    chk("exit_halted_sticky", {31'd0, halted}, 32'd1);
    chk_str("exit_output", "x");

    // Reset pulsed while print_int 123456 is still in DIGIT.
    do_reset();
    got.delete();
    send(32'd1, 32'd123456, n, st);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", {31'd0, char_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, char_data}, 32'd0);
    chk("mid_rst_pending", {31'd0, pending}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    send(32'd11, 32'h7A, n, st);
    wait_idle(500);
    chk_str("after_reset", "z");

    // Randomized traffic with random backpressure vs. a string-level model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      got.delete();
      exp = "";
      mhalt = 1'b0;
      rnd_done = 1'b0;
      fork
        begin
          for (int k = 0; k < 30; k++) begin
            int sel;
            logic [31:0] p, f;
            sel = $urandom_range(0, 19);
            if (sel < 8) begin
              f = 32'd1;
              if (sel < 4) p = $urandom;
              else begin
                p = $urandom_range(0, 999);
                if (sel == 5) p = 32'd0 - p;
              end
              if (!mhalt) exp = {exp, $sformatf("%0d", $signed(p))};
            end else if (sel < 16) begin
              f = 32'd11;
              p = {$urandom_range(0, 16777215), 8'd0} | $urandom_range(32, 126);
              if (!mhalt) exp = $sformatf("%s%c", exp, p[7:0]);
            end else if (sel < 19) begin
              f = 32'd12 + $urandom_range(0, 1000);
              p = $urandom;
            end else begin
              f = 32'd10;
              p = $urandom;
              mhalt = 1'b1;
            end
            send(f, p, n, st);
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(posedge clock); #1;
            char_ready = ($urandom_range(0, 2) != 0);
          end
        end
      join
      @(posedge clock); #1;
      char_ready = 1'b1;
      wait_idle(5000);
      chk_str($sformatf("random_round_%0d", r), exp);
      chk($sformatf("random_halted_%0d", r), {31'd0, halted}, {31'd0, mhalt});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
